// File: rtl/lsu_mem_responder.sv
// Memory-side end of the load/store interface: one outstanding request, word-organised
// data array with registered read, sub-word stores by read-modify-write, extended loads.
module lsu_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_addr,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_val,
    input  logic [2:0]  i_l_s_sel,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rd_val,
    output logic        o_err
);

    typedef enum logic [1:0] {IDLE, RD, RSP} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       mem [0:DEPTH_WORDS-1];
    logic [31:0]       rd_word_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [1:0]        lane_reg;
    logic              wr_en_reg;
    logic [2:0]        sel_reg;
    logic [15:0]       wr_lo_reg;
    logic [31:0]       rd_val_reg, rd_val_next;
    logic              err_reg, err_next;

    logic              accept;
    logic [IDX_W-1:0]  req_idx;
    logic              in_range, sel_illegal, store_unsigned, misaligned, req_err;
    logic              mem_we, mem_re;
    logic [IDX_W-1:0]  mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       merged_word;
    logic [31:0]       shifted_word;
    logic [31:0]       load_val;
    logic [3:0]        lane_en;

    assign o_req_ready = (state_reg == IDLE);
    assign o_rsp_valid = (state_reg == RSP);
    assign o_rd_val    = rd_val_reg;
    assign o_err       = err_reg;

    assign accept         = i_req_valid && o_req_ready;
    assign req_idx        = i_addr[IDX_W+1:2];
    assign in_range       = ({2'b00, i_addr[31:2]} < 32'(DEPTH_WORDS));
    assign sel_illegal    = (i_l_s_sel == 3'b011) || (i_l_s_sel[2:1] == 2'b11);
    assign store_unsigned = i_wr_en && i_l_s_sel[2];
    assign misaligned     = ((i_l_s_sel[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)) ||
                            ((i_l_s_sel[1:0] == 2'b01) && i_addr[0]);
    assign req_err        = !in_range || sel_illegal || store_unsigned || misaligned;

    // Byte lanes for the RMW merge: a half store feeds its low byte to even lanes, high byte to odd.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (sel_reg[1:0] == 2'b00) ? (lane_reg == LANE)
                                                         : (lane_reg[1] == LANE[1]);
            assign merged_word[8*gi +: 8] =
                !lane_en[gi]                                 ? rd_word_reg[8*gi +: 8] :
                ((sel_reg[1:0] == 2'b00) || (LANE[0] == 1'b0)) ? wr_lo_reg[7:0]
                                                             : wr_lo_reg[15:8];
        end
    endgenerate

    assign shifted_word = rd_word_reg >> {lane_reg, 3'b000};

    always_comb begin
        load_val = rd_word_reg;
        case (sel_reg)
            3'b000:  load_val = {{24{shifted_word[7]}}, shifted_word[7:0]};
            3'b001:  load_val = {{16{shifted_word[15]}}, shifted_word[15:0]};
            3'b100:  load_val = {24'h0, shifted_word[7:0]};
            3'b101:  load_val = {16'h0, shifted_word[15:0]};
            default: load_val = rd_word_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        rd_val_next = rd_val_reg;
        err_next    = err_reg;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_waddr   = idx_reg;
        mem_wdata   = merged_word;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    rd_val_next = 32'h0;
                    err_next    = 1'b0;
                    if (req_err) begin
                        err_next   = 1'b1;
                        state_next = RSP;
                    end else if (i_wr_en && (i_l_s_sel[1:0] == 2'b10)) begin
                        mem_we     = 1'b1;
                        mem_waddr  = req_idx;
                        mem_wdata  = i_wr_val;
                        state_next = RSP;
                    end else begin
                        mem_re     = 1'b1;
                        state_next = RD;
                    end
                end
            end
            RD: begin
                state_next = RSP;
                err_next   = 1'b0;
                if (wr_en_reg) begin
                    mem_we      = 1'b1;
                    rd_val_next = 32'h0;
                end else begin
                    rd_val_next = load_val;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_next  = IDLE;
                    rd_val_next = 32'h0;
                    err_next    = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            rd_val_reg <= 32'h0;
            err_reg    <= 1'b0;
            idx_reg    <= '0;
            lane_reg   <= 2'b00;
            wr_en_reg  <= 1'b0;
            sel_reg    <= 3'b000;
            wr_lo_reg  <= 16'h0;
        end else begin
            state_reg  <= state_next;
            rd_val_reg <= rd_val_next;
            err_reg    <= err_next;
            if (accept) begin
                idx_reg   <= req_idx;
                lane_reg  <= i_addr[1:0];
                wr_en_reg <= i_wr_en;
                sel_reg   <= i_l_s_sel;
                wr_lo_reg <= i_wr_val[15:0];
            end
        end
    end

    // Array and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_word_reg <= mem[req_idx];
        end
    end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder: directed vector table, backpressure and
// reset-during-RD sequences, then random traffic against a byte-addressed reference model.
module tb_lsu_mem_responder;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_addr = 32'h0;
    logic        i_wr_en = 1'b0;
    logic [31:0] i_wr_val = 32'h0;
    logic [2:0]  i_l_s_sel = 3'b010;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rd_val;
    logic        o_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_responder #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_addr      (i_addr),
        .i_wr_en     (i_wr_en),
        .i_wr_val    (i_wr_val),
        .i_l_s_sel   (i_l_s_sel),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rd_val    (o_rd_val),
        .o_err       (o_err)
    );

    // Reference memory kept as individual bytes (little-endian).
    logic [7:0] ref_mem [0:4095];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] val;
        logic [2:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model(input logic [31:0] a, input logic w, input logic [31:0] v,
                         input logic [2:0] s, output logic [31:0] rd, output logic er,
                         output int lat);
        int size;
        logic [31:0] u;
        size = (s[1:0] == 2'd0) ? 1 : (s[1:0] == 2'd1) ? 2 : 4;
        er = (s == 3'd3) || (s == 3'd6) || (s == 3'd7) || (w && s[2]) ||
             ((a % size) != 0) || (a >= 32'd4096);
        rd = 32'h0;
        lat = 1;
        if (er) return;
        if (w) begin
            for (int i = 0; i < size; i++) ref_mem[a[11:0] + 12'(i)] = v[8*i +: 8];
            lat = (size == 4) ? 1 : 2;
        end else begin
            u = 32'h0;
            for (int i = 0; i < size; i++) u = u | (32'(ref_mem[a[11:0] + 12'(i)]) << (8*i));
            if (size < 4 && !s[2] && u[8*size-1]) u = u | ~((32'h1 << (8*size)) - 32'h1);
            rd = u;
            lat = 2;
        end
    endtask

    // Issue one request (caller is 1 time unit after a rising edge), wait for the response,
    // hold it for hold cycles, then complete the handshake.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] v,
                        input logic [2:0] s, input int hold, output logic [31:0] rd,
                        output logic er, output int lat, output logic rdy);
        i_req_valid = 1'b1; i_addr = a; i_wr_en = w; i_wr_val = v; i_l_s_sel = s;
        rdy = o_req_ready;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_addr = $urandom; i_wr_en = 1'($urandom); i_wr_val = $urandom; i_l_s_sel = 3'($urandom);
        lat = 1;
        while (!o_rsp_valid && lat < 8) begin
            @(posedge i_clk); #1;
            lat++;
        end
        rd = o_rd_val;
        er = o_err;
        for (int i = 0; i < hold; i++) begin @(posedge i_clk); #1; end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic w,
                             input logic [31:0] v, input logic [2:0] s, input int hold,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic er, rdy;
        int lat;
        xact(a, w, v, s, hold, rd, er, lat, rdy);
        $display("%s addr=0x%08h wr=%0d sel=%03b val=0x%08h -> rd=0x%08h err=%0d lat=%0d",
                 tag, a, w, s, v, rd, er, lat);
        chk({tag, " ready"}, 32'(rdy), 32'h1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rd_val"}, rd, exp_rd);
        chk({tag, " err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] m_rd;
        logic        m_er;
        int          m_lat;
        logic [31:0] a;

        vecs[0]  = '{32'h10,   1'b1, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 1};
        vecs[1]  = '{32'h10,   1'b0, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 2};
        vecs[2]  = '{32'h12,   1'b1, 32'h1234565A, 3'b000, 32'h0,        1'b0, 2};
        vecs[3]  = '{32'h10,   1'b0, 32'h0,        3'b010, 32'hDE5ABEEF, 1'b0, 2};
        vecs[4]  = '{32'h12,   1'b0, 32'h0,        3'b000, 32'h0000005A, 1'b0, 2};
        vecs[5]  = '{32'h13,   1'b0, 32'h0,        3'b000, 32'hFFFFFFDE, 1'b0, 2};
        vecs[6]  = '{32'h13,   1'b0, 32'h0,        3'b100, 32'h000000DE, 1'b0, 2};
        vecs[7]  = '{32'h20,   1'b1, 32'h00000000, 3'b010, 32'h0,        1'b0, 1};
        vecs[8]  = '{32'h20,   1'b1, 32'hABCD8001, 3'b001, 32'h0,        1'b0, 2};
        vecs[9]  = '{32'h20,   1'b0, 32'h0,        3'b010, 32'h00008001, 1'b0, 2};
        vecs[10] = '{32'h20,   1'b0, 32'h0,        3'b001, 32'hFFFF8001, 1'b0, 2};
        vecs[11] = '{32'h20,   1'b0, 32'h0,        3'b101, 32'h00008001, 1'b0, 2};
        vecs[12] = '{32'h22,   1'b0, 32'h0,        3'b010, 32'h0,        1'b1, 1};
        vecs[13] = '{32'h21,   1'b0, 32'h0,        3'b001, 32'h0,        1'b1, 1};
        vecs[14] = '{32'h10,   1'b1, 32'h000000FF, 3'b100, 32'h0,        1'b1, 1};
        vecs[15] = '{32'h1000, 1'b0, 32'h0,        3'b010, 32'h0,        1'b1, 1};
        vecs[16] = '{32'h1000, 1'b1, 32'h55555555, 3'b010, 32'h0,        1'b1, 1};
        vecs[17] = '{32'h10,   1'b0, 32'h0,        3'b011, 32'h0,        1'b1, 1};
        vecs[18] = '{32'h10,   1'b0, 32'h0,        3'b010, 32'hDE5ABEEF, 1'b0, 2};
        vecs[19] = '{32'h20,   1'b0, 32'h0,        3'b010, 32'h00008001, 1'b0, 2};

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        repeat (3) @(posedge i_clk);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("reset req_ready", 32'(o_req_ready), 32'h1);
        chk("reset rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("reset rd_val", o_rd_val, 32'h0);
        chk("reset err", 32'(o_err), 32'h0);

        foreach (vecs[i]) begin
            model(vecs[i].addr, vecs[i].wr, vecs[i].val, vecs[i].sel, m_rd, m_er, m_lat);
            run_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].val,
                      vecs[i].sel, 0, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Backpressure: response held 5 cycles while a second request waits.
        i_req_valid = 1'b1; i_addr = 32'h10; i_wr_en = 1'b0; i_l_s_sel = 3'b010;
        @(posedge i_clk); #1;
        i_addr = 32'h20;
        @(posedge i_clk); #1;
        for (int c = 0; c < 5; c++) begin
            $display("bp cycle %0d: rsp_valid=%0d rd=0x%08h err=%0d req_ready=%0d",
                     c, o_rsp_valid, o_rd_val, o_err, o_req_ready);
            chk($sformatf("bp%0d rsp_valid", c), 32'(o_rsp_valid), 32'h1);
            chk($sformatf("bp%0d rd_val", c), o_rd_val, 32'hDE5ABEEF);
            chk($sformatf("bp%0d err", c), 32'(o_err), 32'h0);
            chk($sformatf("bp%0d req_ready", c), 32'(o_req_ready), 32'h0);
            @(posedge i_clk); #1;
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        chk("bp after hs rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("bp after hs req_ready", 32'(o_req_ready), 32'h1);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("bp second in RD", 32'(o_rsp_valid), 32'h0);
        @(posedge i_clk); #1;
        $display("bp second: rsp_valid=%0d rd=0x%08h err=%0d", o_rsp_valid, o_rd_val, o_err);
        chk("bp second rsp_valid", 32'(o_rsp_valid), 32'h1);
        chk("bp second rd_val", o_rd_val, 32'h00008001);
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;

        // Reset asserted while a byte store sits in RD: the store must be dropped.
        model(32'h30, 1'b1, 32'h11223344, 3'b010, m_rd, m_er, m_lat);
        run_check("rst prep", 32'h30, 1'b1, 32'h11223344, 3'b010, 0, 32'h0, 1'b0, 1);
        i_req_valid = 1'b1; i_addr = 32'h30; i_wr_en = 1'b1; i_wr_val = 32'h99; i_l_s_sel = 3'b000;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        $display("rst mid-op: rsp_valid=%0d rd=0x%08h err=%0d", o_rsp_valid, o_rd_val, o_err);
        chk("rst midop rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("rst midop rd_val", o_rd_val, 32'h0);
        chk("rst midop err", 32'(o_err), 32'h0);
        @(posedge i_clk);
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst release rsp_valid", 32'(o_rsp_valid), 32'h0);
        run_check("rst readback", 32'h30, 1'b0, 32'h0, 3'b010, 0, 32'h11223344, 1'b0, 2);

        // Random traffic over a small initialised window plus out-of-range addresses.
        for (int w = 0; w < 64; w++) begin
            logic [31:0] v;
            v = $urandom;
            model(32'(w * 4), 1'b1, v, 3'b010, m_rd, m_er, m_lat);
            run_check($sformatf("init%0d", w), 32'(w * 4), 1'b1, v, 3'b010, 0, m_rd, m_er, m_lat);
        end
        for (int n = 0; n < 200; n++) begin
            int r;
            logic w;
            logic [31:0] v;
            logic [2:0] s;
            r = $urandom_range(0, 15);
            if (r == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            v = $urandom;
            s = 3'($urandom_range(0, 7));
            model(a, w, v, s, m_rd, m_er, m_lat);
            run_check($sformatf("rand%0d", n), a, w, v, s, $urandom_range(0, 2), m_rd, m_er, m_lat);
            repeat ($urandom_range(0, 1)) begin @(posedge i_clk); #1; end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsu_mem_responder.md
Name: lsu_mem_responder

Overview:
- Handshaked data-memory responder serving the core's load/store requests; the memory-side end of the load/store interface.
- Owns a word-organised data array with synchronous read.
- Stores: byte/half lane placement via read-modify-write.
- Loads: lane extraction with sign/zero extension, so the core receives final register-ready values.
- Flags misaligned, out-of-range and illegal-width requests.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data array.
- IDX_W, 10, word-index width (clog2(DEPTH_WORDS)).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_addr  in  32  byte address.
- i_wr_en  in  1  1 = store, 0 = load.
- i_wr_val  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- i_l_s_sel  in  3  funct3 width code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  core accepts response.
- o_rd_val  out  32  load result, extended; 0 for stores and errors.
- o_err  out  1  request rejected; no memory side effect.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_rsp_valid=0, o_rd_val=0, o_err=0; o_req_ready=1 after release.
  - Array contents are not reset.
  - Reset mid-operation drops the in-flight request: no write occurs, no response is produced.
- States IDLE, RD, RSP. o_req_ready = (state==IDLE). A request is accepted on an edge with i_req_valid & o_req_ready.
- Request checks, evaluated at acceptance:
  - Error if any of the following holds:
    - addr[1:0]!=0 for word;
    - addr[0]!=0 for half;
    - addr[31:2] >= DEPTH_WORDS;
    - i_l_s_sel in {011,110,111};
    - store with i_l_s_sel in {100,101}.
  - On error: IDLE->RSP, o_err=1, o_rd_val=0, no array access.
- Word store: the array word is written at the acceptance edge; IDLE->RSP; o_err=0, o_rd_val=0.
- Byte/half store: array read at the acceptance edge; IDLE->RD.
  - In RD, i_wr_val[7:0] or [15:0] is merged into the read word at lane addr[1:0] (little-endian; byte k = bits 8k+7:8k); other lanes keep their old value.
  - Merged word written at the next edge; RD->RSP.
- Load: array read at the acceptance edge; IDLE->RD.
  - In RD, the selected lane is shifted to bit 0 and extended (000/001 sign-extend; 100/101 zero-extend; 010 whole word).
  - o_rd_val registered at the next edge; RD->RSP.
  - Load response visible 2 edges after acceptance; sub-word store takes 2 edges; word store/error takes 1 edge.
- RSP: o_rsp_valid=1; o_rd_val/o_err held stable until an edge with i_rsp_ready=1, then RSP->IDLE with o_rsp_valid=0.
  - One outstanding request max; no request is accepted while in RD or RSP.
  - Back-to-back throughput is one request per 2–3 cycles.
- Read-after-write: a load accepted the cycle after a store's response handshake sees the stored data, since the write completes before RSP.
- RD and RSP are unconditional in i_req_valid; request inputs are sampled only at acceptance and latched, so changes after acceptance have no effect.

Test Plan:
- Word store then load:
  - Store 0xDEADBEEF at 0x10 -> rsp after 1 edge, err=0.
  - Load word 0x10 -> o_rd_val=0xDEADBEEF, 2 edges after acceptance.
- Byte RMW:
  - After the word above, store byte 0x5A at 0x12 -> word becomes 0xDE5ABEEF.
  - Load byte 0x12 -> 0x0000005A; load byte 0x13 -> 0xFFFFFFDE; load byte-unsigned 0x13 -> 0x000000DE.
- Half:
  - Store half 0x8001 at 0x20 on a zeroed word -> word 0x00008001.
  - Load half 0x20 -> 0xFFFF8001; half-unsigned -> 0x00008001.
- Errors:
  - Load word at 0x22, half at 0x21, byte-unsigned store, and address 0x1000 with DEPTH_WORDS=1024 -> each o_err=1, o_rd_val=0.
  - Memory unchanged, verified by readback.
- Backpressure: hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid, o_rd_val, o_err stable and o_req_ready=0 throughout; the new request is accepted only after the handshake.
- Reset mid-op: assert i_rst_n=0 during RD of a byte store to 0x30 (old 0x11223344) -> outputs zero immediately; readback 0x11223344.
